// File: rtl/sound_scheduler.sv
// Shares one stereo tone generator between alarm, horn and a streamed melody.
// Fixed priority alarm > horn > melody; a pre-empted melody note pauses and resumes.
//
// state  | meaning
// IDLE   | nothing pending, generator silent
// MELODY | playing the buffered melody note
// HORN   | playing the horn tone
// ALARM  | playing the two-tone alarm
// GAP    | silent spacer between two different sources
module sound_scheduler #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 1000000,
  parameter logic [21:0] HORN_DIV    = 22'd113636,
  parameter logic [21:0] ALARM_DIV_A = 22'd56818,
  parameter logic [21:0] ALARM_DIV_B = 22'd75843
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_req,
  input  logic        horn_req,
  input  logic        melody_valid,
  output logic        melody_ready,
  input  logic [21:0] melody_div_l,
  input  logic [21:0] melody_div_r,
  input  logic [3:0]  melody_beats,
  output logic [21:0] note_div_left,
  output logic [21:0] note_div_right,
  output logic [1:0]  active_src
);

  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [21:0]   DIV_SILENT = 22'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MELODY,
    S_HORN,
    S_ALARM,
    S_GAP
  } state_t;

  state_t state, state_nx, pend;

  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic          alarm_phase;
  logic          mel_full;
  logic [21:0]   mel_div_l, mel_div_r;
  logic [3:0]    mel_rem;

  logic playing, beat_tick, mel_done, mel_avail, gap_done, enter_play, xfer;

  assign melody_ready = rst & ~mel_full;
  assign xfer         = melody_valid & melody_ready;

  assign playing   = (state == S_MELODY) || (state == S_HORN) || (state == S_ALARM);
  assign beat_tick = playing && (beat_cnt == BEAT_LAST);
  // A note finishing this cycle must not hold the scheduler in MELODY for one extra cycle.
  assign mel_done  = (state == S_MELODY) && beat_tick && (mel_rem == 4'd1);
  assign mel_avail = mel_full && !mel_done;
  assign gap_done  = (gap_cnt == '0);

  always_comb begin
    pend = S_IDLE;
    if (alarm_req)      pend = S_ALARM;
    else if (horn_req)  pend = S_HORN;
    else if (mel_avail) pend = S_MELODY;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = pend;
      S_GAP:  if (gap_done) state_nx = pend;
      default: begin
        if (pend == S_IDLE)     state_nx = S_IDLE;
        else if (pend != state) state_nx = (GAP_CYCLES > 0) ? S_GAP : pend;
      end
    endcase
  end

  assign enter_play = (state_nx != state) &&
                      ((state_nx == S_MELODY) || (state_nx == S_HORN) || (state_nx == S_ALARM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (enter_play) begin
      beat_cnt <= '0;
    end else if (playing) begin
      beat_cnt <= beat_tick ? '0 : beat_cnt + BW'(1);
    end else begin
      beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if ((state != S_GAP) && (state_nx == S_GAP)) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == S_GAP) && !gap_done) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_phase <= 1'b0;
    end else if ((state != S_ALARM) && (state_nx == S_ALARM)) begin
      alarm_phase <= 1'b0;
    end else if ((state == S_ALARM) && beat_tick) begin
      alarm_phase <= ~alarm_phase;
    end
  end

  // Remaining beats only move while MELODY is audible, so pre-emption pauses the note.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mel_full  <= 1'b0;
      mel_div_l <= DIV_SILENT;
      mel_div_r <= DIV_SILENT;
      mel_rem   <= 4'd0;
    end else if (xfer) begin
      mel_full  <= 1'b1;
      mel_div_l <= melody_div_l;
      mel_div_r <= melody_div_r;
      mel_rem   <= (melody_beats == 4'd0) ? 4'd1 : melody_beats;
    end else if ((state == S_MELODY) && beat_tick) begin
      mel_rem <= mel_rem - 4'd1;
      if (mel_rem == 4'd1) mel_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_div_left  <= DIV_SILENT;
      note_div_right <= DIV_SILENT;
      active_src     <= 2'd0;
    end else begin
      case (state)
        S_ALARM: begin
          note_div_left  <= alarm_phase ? ALARM_DIV_B : ALARM_DIV_A;
          note_div_right <= alarm_phase ? ALARM_DIV_B : ALARM_DIV_A;
          active_src     <= 2'd3;
        end
        S_HORN: begin
          note_div_left  <= HORN_DIV;
          note_div_right <= HORN_DIV;
          active_src     <= 2'd2;
        end
        S_MELODY: begin
          note_div_left  <= mel_div_l;
          note_div_right <= mel_div_r;
          active_src     <= 2'd1;
        end
        default: begin
          note_div_left  <= DIV_SILENT;
          note_div_right <= DIV_SILENT;
          active_src     <= 2'd0;
        end
      endcase
    end
  end

endmodule
